// File: rtl/packet_injector_if.sv
// CPU request/payload and NoC flit link bundle for the packet injector.
// slave = injector side, master = CPU + router side.
interface packet_injector_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_dst;
  logic [5:0]  req_len;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;
  logic        flit_out_valid;
  logic        flit_out_ready;
  logic [63:0] flit_out;
  logic        len_err;
  logic        busy;
  logic [15:0] pkt_count;

  modport slave (
    input  req_valid, req_dst, req_len, data_valid, data, flit_out_ready,
    output req_ready, data_ready, flit_out_valid, flit_out, len_err, busy, pkt_count
  );

  modport master (
    output req_valid, req_dst, req_len, data_valid, data, flit_out_ready,
    input  req_ready, data_ready, flit_out_valid, flit_out, len_err, busy, pkt_count
  );
endinterface

// File: rtl/packet_injector.sv
// Segments CPU packet requests into head/body/tail flits on a single
// registered NoC output, stamping src/dst/pkt_id/seq on every flit.
module packet_injector #(
  parameter logic [7:0] NODE_ID = 8'h00,
  parameter int         MAX_LEN = 32
) (
  input logic nocclk,
  input logic rst,
  packet_injector_if.slave bus
);
  localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);

  // The head flit is loaded the cycle a request is accepted; BODY then takes
  // payload words as the previous flit leaves, giving one flit per cycle.
  typedef enum logic {IDLE, BODY} state_e;

  state_e      state_q, state_d;
  logic        vld_q, vld_d;
  logic [63:0] flit_q, flit_d;
  logic        last_q, last_d;
  logic        len_err_q, len_err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  id_q, id_d;
  logic [7:0]  dst_q, dst_d;
  logic [5:0]  len_q, len_d;
  logic [5:0]  seq_q, seq_d;

  logic       adv, xfer, done, req_acc, dat_acc, tail;
  logic [7:0] id_nx;
  logic [5:0] seq_nx;

  always_comb begin
    adv     = !vld_q || bus.flit_out_ready;
    xfer    = vld_q && bus.flit_out_ready;
    done    = xfer && last_q;
    id_nx   = id_q + {7'd0, done};
    req_acc = (state_q == IDLE) && adv && bus.req_valid;
    dat_acc = (state_q == BODY) && adv && bus.data_valid;
    seq_nx  = seq_q + 6'd1;
    tail    = (seq_nx == len_q);

    state_d   = state_q;
    vld_d     = vld_q;
    flit_d    = flit_q;
    last_d    = last_q;
    len_err_d = 1'b0;
    cnt_d     = cnt_q;
    id_d      = id_q;
    dst_d     = dst_q;
    len_d     = len_q;
    seq_d     = seq_q;

    if (xfer) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    if (req_acc) begin
      if (bus.req_len > MAX_LEN_L) begin
        len_err_d = 1'b1;
      end else begin
        dst_d   = bus.req_dst;
        len_d   = bus.req_len;
        seq_d   = 6'd0;
        vld_d   = 1'b1;
        last_d  = (bus.req_len == 6'd0);
        // id_nx: a new head may load in the same cycle the previous tail leaves
        flit_d  = {(bus.req_len == 6'd0) ? 2'b11 : 2'b00, NODE_ID, bus.req_dst,
                   id_nx, 6'd0, 26'd0, bus.req_len};
        state_d = (bus.req_len == 6'd0) ? IDLE : BODY;
      end
    end

    if (dat_acc) begin
      seq_d  = seq_nx;
      vld_d  = 1'b1;
      last_d = tail;
      flit_d = {tail ? 2'b10 : 2'b01, NODE_ID, dst_q, id_q, seq_nx, bus.data};
      if (tail) state_d = IDLE;
    end

    if (done) begin
      id_d  = id_nx;
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vld_q     <= 1'b0;
      flit_q    <= '0;
      last_q    <= 1'b0;
      len_err_q <= 1'b0;
      cnt_q     <= '0;
      id_q      <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      flit_q    <= flit_d;
      last_q    <= last_d;
      len_err_q <= len_err_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      seq_q     <= seq_d;
    end
  end

  assign bus.req_ready      = (state_q == IDLE) && adv;
  assign bus.data_ready     = (state_q == BODY) && adv;
  assign bus.flit_out_valid = vld_q;
  assign bus.flit_out       = flit_q;
  assign bus.len_err        = len_err_q;
  assign bus.busy           = (state_q != IDLE) || vld_q;
  assign bus.pkt_count      = cnt_q;
endmodule

// File: tb/tb_packet_injector.sv
// Directed + randomized bench for packet_injector; expected flits come from
// a queue built straight from the packet format rules.
module tb_packet_injector;
  localparam logic [7:0] NODE = 8'h03;
  localparam int         MAXL = 32;

  logic nocclk = 1'b0;
  logic rst;
  always #5 nocclk = ~nocclk;

  packet_injector_if bus();
  packet_injector #(.NODE_ID(NODE), .MAX_LEN(MAXL)) dut (
    .nocclk(nocclk), .rst(rst), .bus(bus.slave)
  );

  int          n_tot = 0, n_pass = 0, cyc = 0;
  logic [63:0] exp_q[$];
  int          xfer_cyc[$];
  logic [7:0]  exp_id;
  int          exp_cnt, acc_cyc, rdy_mode;
  logic [7:0]  last_head_id;
  logic        pv = 1'b0, pr = 1'b0;
  logic [63:0] pf = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mk(logic [1:0] t, logic [7:0] d, logic [7:0] id,
                                     logic [5:0] s, logic [31:0] p);
    return {t, NODE, d, id, s, p};
  endfunction

  always @(posedge nocclk) cyc <= cyc + 1;

  always @(negedge nocclk) begin
    if (rdy_mode == 1) bus.flit_out_ready = 1'b1;
    else if (rdy_mode == 2) bus.flit_out_ready = ($urandom_range(3) != 0);
  end

  // Link monitor: checks hold-under-backpressure and every transferred flit.
  always begin
    logic [63:0] e;
    @(negedge nocclk); #4;
    if (rst) pv = 1'b0;
    else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(bus.flit_out_valid), 64'd1);
        chk("hold_flit", bus.flit_out, pf);
      end
      if (bus.flit_out_valid && bus.flit_out_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("extra_flit", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          if (e[63:62] == 2'b00 || e[63:62] == 2'b11) last_head_id = bus.flit_out[45:38];
          if (e[63]) exp_cnt++;
          chk("flit", bus.flit_out, e);
        end
      end
      pv = bus.flit_out_valid; pr = bus.flit_out_ready; pf = bus.flit_out;
    end
  end

  // Call at a negedge; returns at a negedge.
  task automatic send_pkt(input logic [7:0] dst, input logic [5:0] len, input bit rnd);
    logic [31:0] w[64];
    bit hs, bad;
    int n;
    bad = (len > 6'(MAXL));
    for (int i = 0; i < 64; i++) w[i] = rnd ? $urandom : 32'hA + 32'(i);
    bus.req_valid = 1'b1; bus.req_dst = dst; bus.req_len = len;
    n = 0;
    do begin
      #4; hs = bus.req_ready; acc_cyc = cyc;
      @(posedge nocclk); n++;
      if (!hs) @(negedge nocclk);
    end while (!hs && n < 200);
    if (!hs) begin
      chk("req_accept", 64'(hs), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    #1;
    chk("len_err_pulse", 64'(bus.len_err), 64'(bad));
    if (!bad) begin
      exp_q.push_back(mk((len == 0) ? 2'b11 : 2'b00, dst, exp_id, 6'd0, {26'd0, len}));
      for (int i = 1; i <= int'(len); i++)
        exp_q.push_back(mk((i == int'(len)) ? 2'b10 : 2'b01, dst, exp_id, 6'(i), w[i-1]));
      exp_id++;
    end
    @(negedge nocclk);
    bus.req_valid = 1'b0;
    if (!bad) begin
      for (int i = 0; i < int'(len); i++) begin
        n = 0;
        do begin
          bus.data_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
          bus.data = w[i];
          #4; hs = bus.data_valid && bus.data_ready;
          @(posedge nocclk); n++;
          @(negedge nocclk);
        end while (!hs && n < 400);
        if (!hs) begin
          chk("data_accept", 64'(hs), 64'd1);
          break;
        end
      end
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge nocclk); n++;
    end while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 500);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(bus.busy), 64'd0);
    chk("pkt_count", 64'(bus.pkt_count), 64'(exp_cnt));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] f;
    int n;
    rst = 1'b1; rdy_mode = 1; bus.flit_out_ready = 1'b1;
    bus.req_valid = 1'b0; bus.req_dst = '0; bus.req_len = '0;
    bus.data_valid = 1'b0; bus.data = '0;
    exp_id = '0; exp_cnt = 0; last_head_id = '0; acc_cyc = 0;
    repeat (2) @(negedge nocclk);
    chk("rst_valid", 64'(bus.flit_out_valid), 64'd0);
    chk("rst_flit", bus.flit_out, 64'd0);
    chk("rst_len_err", 64'(bus.len_err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_pkt_count", 64'(bus.pkt_count), 64'd0);
    rst = 1'b0;
    @(negedge nocclk);

    // single packet, ready held high
    xfer_cyc.delete();
    send_pkt(8'h05, 6'd2, 1'b0);
    wait_drain();
    chk("t1_nflits", 64'(xfer_cyc.size()), 64'd3);
    chk("t1_latency", 64'(xfer_cyc[0]), 64'(acc_cyc + 1));
    chk("t1_consecutive", 64'(xfer_cyc[2] - xfer_cyc[0]), 64'd2);

    // zero length -> single headtail, next pkt_id
    send_pkt(8'h05, 6'd0, 1'b0);
    wait_drain();
    chk("t2_pkt_id", 64'(last_head_id), 64'd1);

    // backpressure on body seq 1
    rdy_mode = 0; bus.flit_out_ready = 1'b1;
    fork
      send_pkt(8'h07, 6'd4, 1'b0);
      begin
        n = 0;
        do begin
          @(negedge nocclk); n++;
        end while (!(bus.flit_out_valid && bus.flit_out[63:62] == 2'b01 &&
                     bus.flit_out[37:32] == 6'd1) && n < 50);
        chk("bp_found_seq1", 64'(n < 50), 64'd1);
        bus.flit_out_ready = 1'b0;
        f = bus.flit_out;
        repeat (5) begin
          @(posedge nocclk); #1;
          chk("bp_hold", bus.flit_out, f);
          chk("bp_data_ready", 64'(bus.data_ready), 64'd0);
        end
        @(negedge nocclk);
        bus.flit_out_ready = 1'b1;
      end
    join
    rdy_mode = 1;
    wait_drain();

    // over-length request is consumed with a one-cycle len_err
    send_pkt(8'h05, 6'd33, 1'b0);
    chk("lenerr_no_valid", 64'(bus.flit_out_valid), 64'd0);
    @(posedge nocclk); #1;
    chk("lenerr_one_cycle", 64'(bus.len_err), 64'd0);
    chk("lenerr_no_valid2", 64'(bus.flit_out_valid), 64'd0);
    chk("lenerr_count", 64'(bus.pkt_count), 64'(exp_cnt));
    @(negedge nocclk);

    // longest legal packet
    send_pkt(8'h21, 6'(MAXL), 1'b0);
    wait_drain();

    // random traffic with random backpressure and payload gaps
    rdy_mode = 2;
    repeat (30) begin
      logic [5:0] l;
      l = ($urandom_range(7) == 0) ? 6'($urandom_range(63, MAXL + 1))
                                   : 6'($urandom_range(MAXL, 0));
      send_pkt(8'($urandom), l, 1'b1);
    end
    rdy_mode = 1;
    wait_drain();

    // reset while a len=4 packet is in flight
    @(negedge nocclk);
    bus.req_valid = 1'b1; bus.req_dst = 8'h09; bus.req_len = 6'd4;
    @(posedge nocclk); #1;
    exp_q.push_back(mk(2'b00, 8'h09, exp_id, 6'd0, 32'd4));
    @(negedge nocclk);
    bus.req_valid = 1'b0; bus.data_valid = 1'b1; bus.data = 32'hDEAD0001;
    @(posedge nocclk); #2;
    bus.data_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.flit_out_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete(); exp_id = '0; exp_cnt = 0;
    repeat (2) @(negedge nocclk);
    rst = 1'b0;
    send_pkt(8'h0B, 6'd1, 1'b0);
    wait_drain();
    chk("post_rst_pkt_id", 64'(last_head_id), 64'd0);

    // 257 back-to-back len=1 packets from a clean reset
    @(negedge nocclk); rst = 1'b1;
    exp_q.delete(); exp_id = '0; exp_cnt = 0;
    @(negedge nocclk); rst = 1'b0;
    xfer_cyc.delete();
    repeat (257) send_pkt(8'($urandom), 6'd1, 1'b0);
    wait_drain();
    chk("b2b_nflits", 64'(xfer_cyc.size()), 64'd514);
    chk("b2b_no_bubble", 64'(xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0]), 64'd513);
    chk("b2b_last_id", 64'(last_head_id), 64'd0);
    chk("b2b_count", 64'(bus.pkt_count), 64'd257);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
